// File: rtl/simon_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : simon_round_ctrl
//  Description : Round sequencer for the SIMON cipher core. Accepts a start
//                request, pulses key/state load, steps the key schedule and
//                round datapath through NUM_ROUNDS rounds while supplying the
//                round index and constant-sequence (z) bit, then presents a
//                completion handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module simon_round_ctrl #(
  parameter int unsigned WORD_SIZE  = 16,
  parameter int unsigned NUM_ROUNDS = 32,
  parameter logic [61:0] Z_SEQ      = 62'b11111010001001010110000111001101111101000100101011000011100110
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_valid,
  output logic       start_ready,
  input  logic       abort,
  output logic       load_key,
  output logic       round_en,
  output logic [7:0] round_count,
  output logic       z_bit,
  output logic       last_round,
  output logic       done_valid,
  input  logic       done_ready,
  output logic       busy
);

  // Elaboration-time parameter sanity checks.
  if (WORD_SIZE < 16) begin : g_chk_word_size
    $error("simon_round_ctrl: WORD_SIZE must be at least 16");
  end
  if ((NUM_ROUNDS < 2) || (NUM_ROUNDS > 255)) begin : g_chk_num_rounds
    $error("simon_round_ctrl: NUM_ROUNDS must be in 2..255");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [7:0] C_LAST_ROUND = 8'(NUM_ROUNDS - 1);
  localparam logic [5:0] C_Z_LAST     = 6'd61;

  state_e     state_q, state_d;
  logic [7:0] round_q, round_d;
  logic [5:0] zidx_q,  zidx_d;

  logic       w_last;
  logic [5:0] w_zsel;

  // The z sequence is consumed MSB-first, so index 0 selects Z_SEQ[61].
  assign w_last = (round_q == C_LAST_ROUND);
  assign w_zsel = C_Z_LAST - zidx_q;

  // State and counter registers; reset lands directly in IDLE with counters cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      round_q <= 8'd0;
      zidx_q  <= 6'd0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      zidx_q  <= zidx_d;
    end
  end

  // Next-state and counter update; abort overrides every other transition in LOAD/RUN.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    zidx_d  = zidx_q;
    case (state_q)
      ST_IDLE: begin
        round_d = 8'd0;
        zidx_d  = 6'd0;
        if (start_valid) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_d = ST_IDLE;
          round_d = 8'd0;
          zidx_d  = 6'd0;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
          round_d = 8'd0;
          zidx_d  = 6'd0;
        end else if (w_last) begin
          // Counter parks on the final round index while the result is held.
          state_d = ST_DONE;
        end else begin
          round_d = round_q + 8'd1;
          zidx_d  = (zidx_q == C_Z_LAST) ? 6'd0 : (zidx_q + 6'd1);
        end
      end
      ST_DONE: begin
        // A start presented alongside done_ready is not taken until IDLE.
        if (done_ready) begin
          state_d = ST_IDLE;
          round_d = 8'd0;
          zidx_d  = 6'd0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        round_d = 8'd0;
        zidx_d  = 6'd0;
      end
    endcase
  end

  // Output decode purely from registered state and counters.
  always_comb begin
    start_ready = 1'b0;
    load_key    = 1'b0;
    round_en    = 1'b0;
    last_round  = 1'b0;
    done_valid  = 1'b0;
    busy        = 1'b1;
    round_count = round_q;
    z_bit       = Z_SEQ[w_zsel];
    case (state_q)
      ST_IDLE: begin
        start_ready = 1'b1;
        busy        = 1'b0;
      end
      ST_LOAD: begin
        load_key = 1'b1;
      end
      ST_RUN: begin
        round_en   = 1'b1;
        last_round = w_last;
      end
      ST_DONE: begin
        done_valid = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_simon_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_simon_round_ctrl
//  Description : Self-checking bench for simon_round_ctrl. Instance A
//                (32 rounds) runs directed scenarios and random traffic
//                against a timeline model; instance B (72 rounds) checks the
//                z-sequence stream and its wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_simon_round_ctrl;

  localparam int N_A = 32;
  localparam int N_B = 72;
  localparam logic [61:0] ZSEQ = 62'b11111010001001010110000111001101111101000100101011000011100110;

  logic clk;
  logic rst, start_valid, abort, done_ready;
  logic start_ready, load_key, round_en, z_bit, last_round, done_valid, busy;
  logic [7:0] round_count;

  logic rst_b, start_valid_b, abort_b, done_ready_b;
  logic start_ready_b, load_key_b, round_en_b, z_bit_b, last_round_b, done_valid_b, busy_b;
  logic [7:0] round_count_b;

  int n_tests;
  int n_fail;
  int cyc;
  int ren_cnt;
  logic [61:0] zref;

  // Timeline model of instance A: age 0 is the load cycle, ages 1..N are rounds.
  bit m_active;
  bit m_done;
  int m_age;

  simon_round_ctrl #(.NUM_ROUNDS(N_A)) u_dut_a (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .abort(abort), .load_key(load_key), .round_en(round_en), .round_count(round_count),
    .z_bit(z_bit), .last_round(last_round), .done_valid(done_valid),
    .done_ready(done_ready), .busy(busy)
  );

  simon_round_ctrl #(.NUM_ROUNDS(N_B)) u_dut_b (
    .clk(clk), .rst(rst_b), .start_valid(start_valid_b), .start_ready(start_ready_b),
    .abort(abort_b), .load_key(load_key_b), .round_en(round_en_b), .round_count(round_count_b),
    .z_bit(z_bit_b), .last_round(last_round_b), .done_valid(done_valid_b),
    .done_ready(done_ready_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Advance the model by one clock edge using the inputs the DUT is about to sample.
  task automatic model_edge();
    if (m_active) begin
      if (abort) m_active = 1'b0;
      else if (m_age == N_A) begin
        m_active = 1'b0;
        m_done   = 1'b1;
      end else m_age++;
    end else if (m_done) begin
      if (done_ready) m_done = 1'b0;
    end else if (start_valid) begin
      m_active = 1'b1;
      m_age    = 0;
    end
  endtask

  task automatic check_a();
    bit idle;
    bit ren;
    idle = !m_active && !m_done;
    ren  = m_active && (m_age >= 1);
    chk("start_ready", start_ready, idle);
    chk("load_key",    load_key,    m_active && (m_age == 0));
    chk("round_en",    round_en,    ren);
    chk("last_round",  last_round,  ren && (m_age == N_A));
    chk("done_valid",  done_valid,  m_done);
    chk("busy",        busy,        !idle);
    if (idle) begin
      chk("idle_round_count", round_count, 0);
      chk("idle_z_bit",       z_bit,       zref[61]);
    end
    if (ren) begin
      chk("round_count", round_count, m_age - 1);
      chk("z_bit",       z_bit,       zref[61 - ((m_age - 1) % 62)]);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    if (round_en) ren_cnt++;
    check_a();
  endtask

  // Runs a block on A with done_ready high, returns observed round_en count.
  task automatic full_block(input string tag);
    int t_acc;
    int t_done;
    t_acc  = cyc;
    t_done = -1;
    ren_cnt = 0;
    start_valid = 1'b1;
    done_ready  = 1'b1;
    step();
    start_valid = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (done_valid && (t_done < 0)) t_done = cyc;
    end
    chk({tag, "_rounds"},  ren_cnt, N_A);
    chk({tag, "_latency"}, t_done - t_acc, N_A + 2);
  endtask

  initial begin : main
    int k;
    n_tests = 0; n_fail = 0; cyc = 0; ren_cnt = 0;
    zref = ZSEQ;
    m_active = 1'b0; m_done = 1'b0; m_age = 0;
    rst = 1'b1; start_valid = 1'b0; abort = 1'b0; done_ready = 1'b0;
    rst_b = 1'b1; start_valid_b = 1'b0; abort_b = 1'b0; done_ready_b = 1'b0;

    // Reset state.
    #1;
    check_a();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; rst_b = 1'b0;
    check_a();

    // Instance B: 72 rounds, z-sequence and wrap.
    start_valid_b = 1'b1;
    @(posedge clk); #1;
    start_valid_b = 1'b0;
    done_ready_b  = 1'b1;
    chk("b_load_key", load_key_b, 1);
    k = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (round_en_b) begin
        chk("b_round_count", round_count_b, k);
        chk("b_z_bit",       z_bit_b,       zref[61 - (k % 62)]);
        chk("b_last_round",  last_round_b,  k == N_B - 1);
        k++;
      end
      if (done_valid_b) break;
    end
    chk("b_rounds", k, N_B);
    chk("b_done",   done_valid_b, 1);
    done_ready_b = 1'b0;

    // Basic block.
    full_block("basic");

    // Backpressure with start_valid held high throughout.
    done_ready  = 1'b0;
    start_valid = 1'b1;
    for (int i = 0; i < 60 && !done_valid; i++) step();
    chk("bp_reached_done", done_valid, 1);
    repeat (10) step();
    done_ready = 1'b1;
    step();
    chk("bp_back_idle", start_ready, 1);
    done_ready = 1'b0;
    step();
    chk("bp_new_load", load_key, 1);
    start_valid = 1'b0;
    done_ready  = 1'b1;
    for (int i = 0; i < 60 && busy; i++) step();
    chk("bp_idle_again", busy, 0);

    // Abort during round 5, then a full block.
    start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    for (int i = 0; i < 10 && !(round_en && round_count == 8'd5); i++) step();
    chk("abort_at_round5", round_count, 5);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_idle", start_ready, 1);
    repeat (3) step();
    full_block("post_abort");

    // Asynchronous reset at round 17.
    start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    for (int i = 0; i < 30 && !(round_en && round_count == 8'd17); i++) step();
    chk("rst_at_round17", round_count, 17);
    #3;
    rst = 1'b1;
    #1;
    m_active = 1'b0; m_done = 1'b0;
    chk("rst_async_round_en",    round_en,    0);
    chk("rst_async_round_count", round_count, 0);
    chk("rst_async_start_ready", start_ready, 1);
    check_a();
    @(posedge clk); #1;
    rst = 1'b0;
    check_a();
    full_block("post_reset");

    // Random traffic including spurious start_valid/done_ready and aborts.
    for (int i = 0; i < 2500; i++) begin
      start_valid = ($urandom % 3) == 0;
      done_ready  = ($urandom % 2) == 0;
      abort       = ($urandom % 50) == 0;
      step();
    end
    start_valid = 1'b0; abort = 1'b0; done_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
